down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//  Loadable down-counter/timer. It is the counterpart of the free-running up-counter.
//  Counts a loaded value down to zero on enabled cycles and flags terminal count.
//  Optionally auto-reloads for periodic ticks.
//  Used as a delay/period generator feeding control FSMs elsewhere in the design.
// PARAMETERS
//  WIDTH   4   counter and load-value width in bits (>=2)
// PORTS
//  clk          in   1      system clock; all logic on posedge
//  rst          in   1      synchronous, active-high reset
//  load         in   1      capture load_val and start counting
//  load_val     in   WIDTH  start value; also stored as reload value
//  en           in   1      count enable; decrement only on en=1 cycles
//  stop         in   1      abort run; return to IDLE, hold count
//  auto_reload  in   1      1: wrap 0 -> reload value; 0: stop at 0
//  count        out  WIDTH  current count (registered)
//  tc           out  1      one-cycle pulse, registered, on count reaching 0
//  busy         out  1      1 while in RUN
//  done         out  1      1 in DONE until next load/rst
// BEHAVIOUR
//  Reset and clocking
//  - rst=1 at posedge: count=0, reload_reg=0, tc=0, busy=0, done=0, state=IDLE.
//  - Priority each edge: rst > load > stop > en.
//  - All outputs are registered. There is no combinational path from inputs to outputs.
//  States
//  - IDLE: waiting for load. count holds.
//  - RUN: counting; busy=1.
//  - DONE: count=0, done=1.
//  Loading
//  - load=1 in any state: count<=load_val and reload_reg<=load_val. done<=0, tc<=0.
//  - If load_val!=0, next state is RUN. Counting starts the cycle after load.
//  - If load_val==0, next state is DONE with done<=1. tc is NOT pulsed.
//  Counting in RUN
//  - en=0: count, state and flags all hold; tc<=0.
//  - en=1, count>1: count<=count-1; tc<=0.
//  - en=1, count==1: count<=0 and tc<=1 on the same edge.
//    With auto_reload=0 on that edge, the next state is DONE (busy<=0, done<=1).
//    With auto_reload=1 on that edge, the state stays RUN.
//  - en=1, count==0 (only reachable with auto_reload): count<=reload_reg; tc<=0.
//    Period is reload_reg+1 enabled cycles per tc.
//  - Clearing auto_reload while count==0 in RUN: the next en cycle goes to DONE.
//    count stays 0 and no extra tc is issued.
//  Other controls
//  - stop=1 in RUN: state<=IDLE, busy<=0, count holds, tc<=0.
//    stop has no effect in IDLE or DONE.
//  - Load during RUN restarts immediately. No tc is issued for the aborted run.
//  - tc is never high for 2 consecutive cycles.
//  - All arithmetic is modulo 2^WIDTH. Underflow is impossible by construction.
//  - rst mid-run aborts without a tc pulse.
// TESTING  (WIDTH=4, clk period 20)
//  1. load=1,load_val=3, then en=1 held, auto_reload=0
//     -> count 3,2,1,0; tc=1 only at count=0 cycle; then busy=0, done=1, count stays 0.
//  2. load_val=2, auto_reload=1, en=1 held
//     -> count 2,1,0,2,1,0,...; tc every 3rd cycle; busy stays 1, done=0.
//  3. load_val=5, en toggling 1,0,1,0
//     -> count decrements only on en=1 edges; 5,4,4,3,3...; tc only at 0.
//  4. load_val=0 -> next cycle done=1, busy=0, tc stays 0 throughout.
//  5. load_val=9, at count=5 assert rst one cycle -> all outputs 0 next edge, state IDLE.
//     At count=2, load with load_val=7 -> count=7 next edge, no tc.
//  6. load_val=15 (max), run to completion -> exactly 15 enabled cycles to tc.
//     stop at count=6 -> busy=0, count holds 6; further en has no effect.

Source files
------------

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for the loadable down-counter timer.
// The master side drives load/run controls; the slave side returns count and status.
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, en, stop, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, en, stop, auto_reload,
        output count, tc, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload,
// used as a delay/period generator for control FSMs.
//
//  state | meaning
//  ------+-----------------------------------------------
//  IDLE  | waiting for load; count holds
//  RUN   | decrementing on en cycles; busy=1
//  DONE  | one-shot finished; count=0, done=1 until load
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    down_counter_timer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             tc_q, tc_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            count_q  <= count_n;
            reload_q <= reload_n;
            tc_q     <= tc_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        count_n  = count_q;
        reload_n = reload_q;
        tc_n     = 1'b0;

        if (bus.load) begin
            count_n  = bus.load_val;
            reload_n = bus.load_val;
            state_n  = (bus.load_val != '0) ? RUN : DONE;
        end else if (state_q == RUN) begin
            if (bus.stop) begin
                state_n = IDLE;
            end else if (bus.en) begin
                if (count_q > WIDTH'(1)) begin
                    count_n = count_q - WIDTH'(1);
                end else if (count_q == WIDTH'(1)) begin
                    count_n = '0;
                    tc_n    = 1'b1;
                    if (!bus.auto_reload)
                        state_n = DONE;
                end else begin
                    // count==0 is only reachable in RUN via auto-reload; the tc
                    // for this period was already issued on the 1->0 step
                    if (bus.auto_reload)
                        count_n = reload_q;
                    else
                        state_n = DONE;
                end
            end
        end

        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed test of down_counter_timer: one-shot, auto-reload, gated enable,
// zero load, reset/reload mid-run, max value, stop, back-to-back loads.
module tb_down_counter_timer;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    down_counter_timer_if #(.WIDTH(WIDTH)) ifc ();

    down_counter_timer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #10 clk = ~clk;

    // packed {count, tc, busy, done}
    function automatic logic [6:0] st(input int c, input bit t, input bit b, input bit d);
        logic [3:0] cv;
        cv = c[3:0];
        return {cv, t, b, d};
    endfunction

    function automatic logic [6:0] obs();
        return {ifc.count, ifc.tc, ifc.busy, ifc.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (obs() !== st(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_state got=%b exp=%b", obs(), st(0, 0, 0, 0));
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (obs() !== st(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL idle_after_reset got=%b exp=%b", obs(), st(0, 0, 0, 0));
        end
    endtask

    task automatic test_oneshot();
        logic [6:0] exp_s [5];
        exp_s = '{st(2,0,1,0), st(1,0,1,0), st(0,1,0,1), st(0,0,0,1), st(0,0,0,1)};
        ifc.load = 1'b1; ifc.load_val = 4'd3; ifc.en = 1'b1; ifc.auto_reload = 1'b0;
        step();
        n_cmp++;
        if (obs() !== st(3, 0, 1, 0)) begin
            n_err++;
            $display("FAIL oneshot_load got=%b exp=%b", obs(), st(3, 0, 1, 0));
        end
        ifc.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (obs() !== exp_s[i]) begin
                n_err++;
                $display("FAIL oneshot_step%0d got=%b exp=%b", i, obs(), exp_s[i]);
            end
        end
    endtask

    task automatic test_auto_reload();
        logic [6:0] exp_s [6];
        exp_s = '{st(1,0,1,0), st(0,1,1,0), st(2,0,1,0), st(1,0,1,0), st(0,1,1,0), st(2,0,1,0)};
        ifc.load = 1'b1; ifc.load_val = 4'd2; ifc.en = 1'b1; ifc.auto_reload = 1'b1;
        step();
        n_cmp++;
        if (obs() !== st(2, 0, 1, 0)) begin
            n_err++;
            $display("FAIL autoreload_load got=%b exp=%b", obs(), st(2, 0, 1, 0));
        end
        ifc.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (obs() !== exp_s[i]) begin
                n_err++;
                $display("FAIL autoreload_step%0d got=%b exp=%b", i, obs(), exp_s[i]);
            end
        end
        // run down to 0 again, then drop auto_reload while sitting at 0
        step();
        step();
        n_cmp++;
        if (obs() !== st(0, 1, 1, 0)) begin
            n_err++;
            $display("FAIL autoreload_tc3 got=%b exp=%b", obs(), st(0, 1, 1, 0));
        end
        ifc.auto_reload = 1'b0;
        step();
        n_cmp++;
        if (obs() !== st(0, 0, 0, 1)) begin
            n_err++;
            $display("FAIL autoreload_clear got=%b exp=%b", obs(), st(0, 0, 0, 1));
        end
    endtask

    task automatic test_en_toggle();
        int exp_c [9];
        logic [6:0] e;
        exp_c = '{4, 4, 3, 3, 2, 2, 1, 1, 0};
        ifc.load = 1'b1; ifc.load_val = 4'd5; ifc.en = 1'b1; ifc.auto_reload = 1'b0;
        step();
        n_cmp++;
        if (obs() !== st(5, 0, 1, 0)) begin
            n_err++;
            $display("FAIL entoggle_load got=%b exp=%b", obs(), st(5, 0, 1, 0));
        end
        ifc.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ifc.en = (i % 2 == 0);
            step();
            e = st(exp_c[i], i == 8, i < 8, i == 8);
            n_cmp++;
            if (obs() !== e) begin
                n_err++;
                $display("FAIL entoggle_step%0d got=%b exp=%b", i, obs(), e);
            end
        end
        ifc.en = 1'b1;
    endtask

    task automatic test_load_zero();
        ifc.load = 1'b1; ifc.load_val = 4'd0; ifc.en = 1'b1;
        step();
        ifc.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs() !== st(0, 0, 0, 1)) begin
                n_err++;
                $display("FAIL loadzero_cyc%0d got=%b exp=%b", i, obs(), st(0, 0, 0, 1));
            end
            step();
        end
    endtask

    task automatic test_rst_and_reload_midrun();
        ifc.load = 1'b1; ifc.load_val = 4'd9; ifc.en = 1'b1; ifc.auto_reload = 1'b0;
        step();
        ifc.load = 1'b0;
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if (obs() !== st(5, 0, 1, 0)) begin
            n_err++;
            $display("FAIL midrun_at5 got=%b exp=%b", obs(), st(5, 0, 1, 0));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (obs() !== st(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL midrun_rst got=%b exp=%b", obs(), st(0, 0, 0, 0));
        end
        step();
        n_cmp++;
        if (obs() !== st(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL midrun_idle_hold got=%b exp=%b", obs(), st(0, 0, 0, 0));
        end
        ifc.load = 1'b1; ifc.load_val = 4'd9;
        step();
        ifc.load = 1'b0;
        for (int c = 8; c >= 2; c--) begin
            step();
            n_cmp++;
            if (obs() !== st(c, 0, 1, 0)) begin
                n_err++;
                $display("FAIL midrun_count%0d got=%b exp=%b", c, obs(), st(c, 0, 1, 0));
            end
        end
        ifc.load = 1'b1; ifc.load_val = 4'd7;
        step();
        ifc.load = 1'b0;
        n_cmp++;
        if (obs() !== st(7, 0, 1, 0)) begin
            n_err++;
            $display("FAIL midrun_reload got=%b exp=%b", obs(), st(7, 0, 1, 0));
        end
    endtask

    task automatic test_max_and_stop();
        int n;
        ifc.load = 1'b1; ifc.load_val = 4'd15; ifc.en = 1'b1; ifc.auto_reload = 1'b0;
        step();
        ifc.load = 1'b0;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (ifc.tc === 1'b1) break;
        end
        n_cmp++;
        if (n !== 15) begin
            n_err++;
            $display("FAIL max_cycles_to_tc got=%0d exp=15", n);
        end
        n_cmp++;
        if (obs() !== st(0, 1, 0, 1)) begin
            n_err++;
            $display("FAIL max_final got=%b exp=%b", obs(), st(0, 1, 0, 1));
        end
        ifc.load = 1'b1; ifc.load_val = 4'd15;
        step();
        ifc.load = 1'b0;
        for (int i = 0; i < 9; i++) step();
        n_cmp++;
        if (obs() !== st(6, 0, 1, 0)) begin
            n_err++;
            $display("FAIL stop_pre got=%b exp=%b", obs(), st(6, 0, 1, 0));
        end
        ifc.stop = 1'b1;
        step();
        ifc.stop = 1'b0;
        n_cmp++;
        if (obs() !== st(6, 0, 0, 0)) begin
            n_err++;
            $display("FAIL stop_apply got=%b exp=%b", obs(), st(6, 0, 0, 0));
        end
        for (int i = 0; i < 3; i++) step();
        n_cmp++;
        if (obs() !== st(6, 0, 0, 0)) begin
            n_err++;
            $display("FAIL stop_hold got=%b exp=%b", obs(), st(6, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_s [5];
        exp_s = '{st(4,0,1,0), st(3,0,1,0), st(1,0,1,0), st(0,1,0,1), st(2,0,1,0)};
        ifc.en = 1'b1; ifc.auto_reload = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ifc.load     = (i == 0 || i == 2 || i == 4);
            ifc.load_val = (i == 0) ? 4'd4 : (i == 2) ? 4'd1 : 4'd2;
            step();
            n_cmp++;
            if (obs() !== exp_s[i]) begin
                n_err++;
                $display("FAIL b2b_step%0d got=%b exp=%b", i, obs(), exp_s[i]);
            end
        end
        ifc.load = 1'b0;
        step();
        n_cmp++;
        if (obs() !== st(1, 0, 1, 0)) begin
            n_err++;
            $display("FAIL b2b_after got=%b exp=%b", obs(), st(1, 0, 1, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.load = 1'b0; ifc.load_val = '0; ifc.en = 1'b0;
        ifc.stop = 1'b0; ifc.auto_reload = 1'b0;
        test_reset();
        test_oneshot();
        test_auto_reload();
        test_en_toggle();
        test_load_zero();
        test_rst_and_reload_midrun();
        test_max_and_stop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
